// File: rtl/damc_pkg.sv
// Shared constants and encodings for the DAMC lookup responder.
// Port constants, registration status codes and FSM states.
package damc_pkg;

    localparam logic [4:0] DAMC_PORT_INVALID = 5'h0;
    localparam logic [4:0] DAMC_PORT_UNREACH = 5'h1F;

    typedef enum logic [1:0] {
        REG_NEW     = 2'd0,
        REG_UPD     = 2'd1,
        REG_FULL    = 2'd2,
        REG_ILLEGAL = 2'd3
    } reg_status_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LK_SCAN  = 3'd1,
        S_LK_RSP   = 3'd2,
        S_RG_SCAN  = 3'd3,
        S_RG_WRITE = 3'd4
    } state_e;

    function automatic logic port_legal(input logic [4:0] p);
        return (p != DAMC_PORT_INVALID) && (p != DAMC_PORT_UNREACH);
    endfunction

endpackage

// File: rtl/damc_req_fifo.sv
// Synchronous FIFO holding pending lookup addresses.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module damc_req_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/damc_lookup_responder.sv
// DAMC lookup responder: address->port table, queued sequential lookups.
// Optional one-entry hit cache enabled by defining DAMC_HIT_CACHE_EN.
import damc_pkg::*;

module damc_lookup_responder #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int QDEPTH = 4
) (
    input  logic        iClk,
    input  logic        iResetN,
    input  logic        DRC_DAMC_lookupValid,
    input  logic [15:0] DRC_DAMC_lookupDeviceAddr,
    output logic        DRC_DAMC_lookupRspValid,
    output logic [4:0]  DRC_DAMC_lookupRspPortID,
    input  logic        DAMC_regValid,
    output logic        DAMC_regReady,
    input  logic [15:0] DAMC_regAddr,
    input  logic [4:0]  DAMC_regPort,
    output logic        DAMC_regDone,
    output logic [1:0]  DAMC_regStatus,
    output logic        DAMC_lookupOverflow,
    input  logic        DAMC_clrOverflow
);

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      lk_addr;
    logic [15:0]      rg_addr;
    logic [4:0]       rg_port;
    logic             rg_illegal;
    logic             mt_found;
    logic             fr_found;
    logic [IDX_W-1:0] mt_idx;
    logic [IDX_W-1:0] fr_idx;

    logic             tbl_valid [DEPTH];
    logic [15:0]      tbl_addr  [DEPTH];
    logic [4:0]       tbl_port  [DEPTH];

    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [15:0]      q_head;
    logic             drop;
    logic             last;
    logic             cur_hit;
    logic             cur_match;
    logic             cur_free;

`ifdef DAMC_HIT_CACHE_EN
    logic             cache_valid;
    logic [15:0]      cache_addr;
    logic [4:0]       cache_port;
    logic             cache_hit;

    assign cache_hit = cache_valid && (cache_addr == q_head);
`endif

    damc_req_fifo #(
        .WIDTH (16),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iResetN),
        .push  (DRC_DAMC_lookupValid),
        .pop   (q_pop),
        .wdata (DRC_DAMC_lookupDeviceAddr),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign q_pop         = (state == S_IDLE) && !q_empty;
    assign drop          = DRC_DAMC_lookupValid && q_full && !q_pop;
    assign DAMC_regReady = (state == S_IDLE) && q_empty;

    assign last      = (idx == IDX_W'(DEPTH - 1));
    assign cur_hit   = tbl_valid[idx] && (tbl_addr[idx] == lk_addr);
    assign cur_match = tbl_valid[idx] && (tbl_addr[idx] == rg_addr);
    assign cur_free  = !tbl_valid[idx];

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            state                    <= S_IDLE;
            idx                      <= '0;
            lk_addr                  <= '0;
            rg_addr                  <= '0;
            rg_port                  <= '0;
            rg_illegal               <= 1'b0;
            mt_found                 <= 1'b0;
            fr_found                 <= 1'b0;
            mt_idx                   <= '0;
            fr_idx                   <= '0;
            DRC_DAMC_lookupRspValid  <= 1'b0;
            DRC_DAMC_lookupRspPortID <= '0;
            DAMC_regDone             <= 1'b0;
            DAMC_regStatus           <= REG_NEW;
            DAMC_lookupOverflow      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_addr[i]  <= '0;
                tbl_port[i]  <= '0;
            end
`ifdef DAMC_HIT_CACHE_EN
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_port  <= '0;
`endif
        end else begin
            DRC_DAMC_lookupRspValid <= 1'b0;
            DAMC_regDone            <= 1'b0;

            // A new drop wins over a same-cycle clear
            if (drop)
                DAMC_lookupOverflow <= 1'b1;
            else if (DAMC_clrOverflow)
                DAMC_lookupOverflow <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (!q_empty) begin
                        lk_addr <= q_head;
                        idx     <= '0;
                        state   <= S_LK_SCAN;
`ifdef DAMC_HIT_CACHE_EN
                        if (cache_hit) begin
                            DRC_DAMC_lookupRspPortID <= cache_port;
                            DRC_DAMC_lookupRspValid  <= 1'b1;
                            state                    <= S_LK_RSP;
                        end
`endif
                    end else if (DAMC_regValid) begin
                        rg_addr  <= DAMC_regAddr;
                        rg_port  <= DAMC_regPort;
                        idx      <= '0;
                        mt_found <= 1'b0;
                        fr_found <= 1'b0;
                        if (port_legal(DAMC_regPort)) begin
                            rg_illegal <= 1'b0;
                            state      <= S_RG_SCAN;
                        end else begin
                            rg_illegal <= 1'b1;
                            state      <= S_RG_WRITE;
                        end
                    end
                end

                S_LK_SCAN: begin
                    if (cur_hit) begin
                        DRC_DAMC_lookupRspPortID <= tbl_port[idx];
                        DRC_DAMC_lookupRspValid  <= 1'b1;
                        state                    <= S_LK_RSP;
`ifdef DAMC_HIT_CACHE_EN
                        cache_valid <= 1'b1;
                        cache_addr  <= lk_addr;
                        cache_port  <= tbl_port[idx];
`endif
                    end else if (last) begin
                        DRC_DAMC_lookupRspPortID <= DAMC_PORT_UNREACH;
                        DRC_DAMC_lookupRspValid  <= 1'b1;
                        state                    <= S_LK_RSP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_LK_RSP: begin
                    state <= S_IDLE;
                end

                S_RG_SCAN: begin
                    if (cur_match && !mt_found) begin
                        mt_found <= 1'b1;
                        mt_idx   <= idx;
                    end
                    if (cur_free && !fr_found) begin
                        fr_found <= 1'b1;
                        fr_idx   <= idx;
                    end
                    if (last)
                        state <= S_RG_WRITE;
                    else
                        idx <= idx + 1'b1;
                end

                S_RG_WRITE: begin
                    DAMC_regDone <= 1'b1;
                    state        <= S_IDLE;
                    if (rg_illegal) begin
                        DAMC_regStatus <= REG_ILLEGAL;
                    end else if (mt_found) begin
                        tbl_port[mt_idx] <= rg_port;
                        DAMC_regStatus   <= REG_UPD;
`ifdef DAMC_HIT_CACHE_EN
                        cache_valid <= 1'b0;
`endif
                    end else if (fr_found) begin
                        tbl_valid[fr_idx] <= 1'b1;
                        tbl_addr[fr_idx]  <= rg_addr;
                        tbl_port[fr_idx]  <= rg_port;
                        DAMC_regStatus    <= REG_NEW;
`ifdef DAMC_HIT_CACHE_EN
                        cache_valid <= 1'b0;
`endif
                    end else begin
                        DAMC_regStatus <= REG_FULL;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_damc_lookup_responder.sv
// Directed bench for damc_lookup_responder with a response scoreboard.
// Expected ports/latencies are queued at request time and checked on RspValid.
module tb_damc_lookup_responder;

    typedef struct {
        logic [4:0] port;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          rsp_cnt = 0;

    logic        clk;
    logic        rst_n;
    logic        lk_valid;
    logic [15:0] lk_addr;
    logic        rsp_valid;
    logic [4:0]  rsp_port;
    logic        reg_valid;
    logic        reg_ready;
    logic [15:0] reg_addr;
    logic [4:0]  reg_port;
    logic        reg_done;
    logic [1:0]  reg_status;
    logic        ovf;
    logic        clr_ovf;

    damc_lookup_responder #(
        .DEPTH  (16),
        .IDX_W  (4),
        .QDEPTH (4)
    ) dut (
        .iClk                      (clk),
        .iResetN                   (rst_n),
        .DRC_DAMC_lookupValid      (lk_valid),
        .DRC_DAMC_lookupDeviceAddr (lk_addr),
        .DRC_DAMC_lookupRspValid   (rsp_valid),
        .DRC_DAMC_lookupRspPortID  (rsp_port),
        .DAMC_regValid             (reg_valid),
        .DAMC_regReady             (reg_ready),
        .DAMC_regAddr              (reg_addr),
        .DAMC_regPort              (reg_port),
        .DAMC_regDone              (reg_done),
        .DAMC_regStatus            (reg_status),
        .DAMC_lookupOverflow       (ovf),
        .DAMC_clrOverflow          (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid) begin
            rsp_cnt++;
            chk("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_port", 32'(rsp_port), 32'(e.port));
                if (e.cyc >= 0) chk("rsp_latency", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; the pulse is sampled at the next posedge.
    task automatic lookup(input logic [15:0] a, input logic [4:0] p,
                          input int lat, input bit keep);
        exp_t e;
        lk_valid = 1'b1;
        lk_addr  = a;
        if (keep) begin
            e.port = p;
            e.cyc  = (lat < 0) ? -1 : cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        lk_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reg(input logic [15:0] a, input logic [4:0] p,
                          input logic [1:0] st);
        int n = 0;
        while (!reg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reg_ready", reg_ready, 1);
        reg_valid = 1'b1;
        reg_addr  = a;
        reg_port  = p;
        @(negedge clk);
        reg_valid = 1'b0;
        n = 0;
        while (!reg_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reg_done", reg_done, 1);
        chk("reg_status", reg_status, st);
        @(negedge clk);
    endtask

    initial begin
        int c0;
        rst_n     = 1'b0;
        lk_valid  = 1'b0;
        lk_addr   = '0;
        reg_valid = 1'b0;
        reg_addr  = '0;
        reg_port  = '0;
        clr_ovf   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_port", rsp_port, 0);
        chk("rst_reg_ready", reg_ready, 1);
        chk("rst_reg_done", reg_done, 0);
        chk("rst_reg_status", reg_status, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First registration and hit at entry 0
        do_reg(16'h1234, 5'd3, 2'd0);
        lookup(16'h1234, 5'd3, 3, 1);
        wait_drain();

        // Miss scans the whole table
        lookup(16'hBEEF, 5'h1F, 18, 1);
        wait_drain();

        // Update, then illegal ports leave the table alone
        do_reg(16'h1234, 5'd7, 2'd1);
        lookup(16'h1234, 5'd7, -1, 1);
        wait_drain();
        do_reg(16'h1234, 5'd0, 2'd3);
        do_reg(16'h5555, 5'h1F, 2'd3);
        lookup(16'h1234, 5'd7, -1, 1);
        wait_drain();
        lookup(16'h5555, 5'h1F, -1, 1);
        wait_drain();

        // Fill entries 1..15, then overflow the table
        for (int i = 1; i < 16; i++)
            do_reg(16'hA000 + 16'(i), 5'(i + 1), 2'd0);
        do_reg(16'hB000, 5'd9, 2'd2);
        lookup(16'hB000, 5'h1F, -1, 1);
        wait_drain();
        do_reg(16'hA00F, 5'd20, 2'd1);
        lookup(16'hA00F, 5'd20, 18, 1);
        wait_drain();
        lookup(16'h1234, 5'd7, -1, 1);
        wait_drain();
        for (int i = 1; i < 15; i++) begin
            lookup(16'hA000 + 16'(i), 5'(i + 1), -1, 1);
            wait_drain();
        end

        // Queue overflow while the FSM is busy on a miss
        c0 = rsp_cnt;
        lookup(16'hBEEF, 5'h1F, -1, 1);
        @(negedge clk);
        lookup(16'hA001, 5'd2, -1, 1);
        lookup(16'hA002, 5'd3, -1, 1);
        lookup(16'hA003, 5'd4, -1, 1);
        lookup(16'hA004, 5'd5, -1, 1);
        lookup(16'hA005, 5'd6, -1, 0);
        chk("ovf_set", ovf, 1);
        wait_drain();
        repeat (30) @(negedge clk);
        chk("ovf_rsp_count", rsp_cnt - c0, 5);
        chk("ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Reset during a scan with two requests queued
        lookup(16'hBEEF, 5'h1F, -1, 1);
        @(negedge clk);
        lookup(16'hA001, 5'd2, -1, 1);
        lookup(16'hA002, 5'd3, -1, 1);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = rsp_cnt;
        repeat (40) @(negedge clk);
        chk("rst_no_rsp", rsp_cnt - c0, 0);
        chk("rst_ready_after", reg_ready, 1);
        lookup(16'h1234, 5'h1F, 18, 1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/damc_lookup_responder.md
Name: damc_lookup_responder

Overview:
- Device Address Management Controller (DAMC) lookup responder; the answering end of the DRC→DAMC lookup interface.
- Holds a table mapping 16-bit device addresses to 5-bit port IDs.
- Takes one-cycle lookup pulses from DRC, queues them, and scans the table sequentially.
- Returns one response pulse per request: the port ID on a hit, 5'h1F (unreachable) on a miss. A management-side registration interface fills the table.

Parameters:
- DEPTH, 16, number of table entries (power of 2, 2..64)
- IDX_W, 4, log2(DEPTH)
- QDEPTH, 4, lookup request queue depth (power of 2)

Ports:
- iClk  in  1  clock
- iResetN  in  1  asynchronous active-low reset
- DRC_DAMC_lookupValid  in  1  one-cycle lookup request pulse
- DRC_DAMC_lookupDeviceAddr  in  16  address to resolve
- DRC_DAMC_lookupRspValid  out  1  one-cycle response pulse
- DRC_DAMC_lookupRspPortID  out  5  resolved port; 5'h1F=unreachable; 0 never driven with RspValid
- DAMC_regValid  in  1  registration request
- DAMC_regReady  out  1  registration accepted when Valid&Ready
- DAMC_regAddr  in  16  address to register
- DAMC_regPort  in  5  port to bind
- DAMC_regDone  out  1  one-cycle completion pulse
- DAMC_regStatus  out  2  0=new entry, 1=updated existing, 2=table full, 3=illegal port; valid with regDone
- DAMC_lookupOverflow  out  1  sticky: a lookup arrived while the queue was full
- DAMC_clrOverflow  in  1  clears DAMC_lookupOverflow

Behaviour:
- Reset, asynchronous on iResetN low:
  - All entry valid bits cleared; queue emptied; FSM to IDLE.
  - All outputs 0, except DAMC_regReady=1.
- Lookup queue:
  - A lookupValid pulse pushes the address into the queue.
  - If the queue is full, the request is dropped and Overflow is set. No response is generated for a dropped request.
  - A push and a pop in the same cycle are legal when full.
  - clrOverflow together with a new overflow in the same cycle leaves Overflow set.
- FSM states: IDLE, LK_SCAN, LK_RSP, RG_SCAN, RG_WRITE.
- IDLE:
  - Queue non-empty: pop the head into a holding register, idx=0, go to LK_SCAN. Lookups take priority over registration.
  - Otherwise, if regValid&regReady: capture addr/port, then:
    - regPort==0 or 5'h1F: go to RG_WRITE with status 3 and no write.
    - Otherwise: go to RG_SCAN.
  - regReady=1 only in IDLE with the queue empty.
- LK_SCAN:
  - Compare one entry per cycle: entry[idx].valid && addr match.
  - On a hit, latch the port and go to LK_RSP.
  - When idx==DEPTH-1 without a hit, latch 5'h1F and go to LK_RSP.
  - Otherwise idx++.
- LK_RSP: RspValid=1 for exactly one cycle with the latched port, then IDLE.
- Lookup latency (request pulse in cycle T, queue empty, FSM idle):
  - Hit at entry i: RspValid in cycle T+3+i.
  - Miss: RspValid in cycle T+2+DEPTH.
- Responses are returned in strict request order.
- RG_SCAN:
  - Scan all entries.
  - Record the first matching valid entry; if there is none, record the lowest-index invalid entry.
  - After the last index, go to RG_WRITE.
- RG_WRITE:
  - Match found: overwrite its port, status 1.
  - No match but a free entry: write the new entry, status 0.
  - No match and no free entry: no write, status 2.
  - Pulse regDone, then IDLE.
- Lookups arriving during a registration are queued. A lookup popped after RG_WRITE sees the updated table.
- Reset mid-scan: the in-flight request and all queued requests are discarded; no response is produced.

Optional Feature:
- Macro: DAMC_HIT_CACHE_EN.
- Enabled:
  - A one-entry cache {valid, addr, port} is loaded on every lookup hit.
  - In IDLE, when the queue head matches the cache, pop the head and go directly to LK_RSP with the cached port. Hit latency becomes T+2.
  - The cache is invalidated by reset and by any RG_WRITE that writes the table.
- Disabled: no cache logic; all lookups scan.

Decomposition:
- Package damc_pkg holds:
  - Constants DAMC_PORT_INVALID=5'h0 and DAMC_PORT_UNREACH=5'h1F.
  - regStatus encodings REG_NEW, REG_UPD, REG_FULL, REG_ILLEGAL.
  - FSM state encodings.
- One sub-module: damc_req_fifo, a parameterised synchronous FIFO (width 16, depth QDEPTH) with full/empty flags.

Test Plan:
- Register addr 16'h1234→port 3 (status 0), then look up 16'h1234 → RspValid at T+3 (entry 0) with PortID=3.
- Look up unregistered 16'hBEEF with DEPTH=16 → RspValid at T+18 with PortID=5'h1F.
- Re-register 16'h1234→port 7 → status 1; the next lookup returns 7. Register with port 0 or 5'h1F → status 3 and the table is unchanged.
- Fill all 16 entries, then register a 17th address → status 2. Every lookup of the first 16 addresses returns the correct port.
- Send 5 back-to-back lookup pulses while the FSM is busy (QDEPTH=4) → Overflow=1 and exactly 4 in-order responses. clrOverflow clears the flag.
- Assert reset during LK_SCAN with 2 requests queued → no RspValid follows. After release, a lookup of a previously registered address → 5'h1F (table cleared).
